// File: rtl/dut_capture_ctrl.sv
// Capture sequencer: arm on start, flush pipeline-fill beats, optionally wait
// for a trigger edge, then write a programmed number of lines to capture RAM.
module dut_capture_ctrl #(
    parameter int unsigned ADC_MAX_DATA_SIZE = 16,
    parameter int unsigned BRAM_WORD_NUM     = 16,
    parameter int unsigned BRAM_ADDR_WIDTH   = 10,
    parameter int unsigned FLUSH_BEATS       = 2
) (
    input  logic                                        i_dut_capture_clk,
    input  logic                                        i_dut_capture_reset_n,
    input  logic                                        i_dut_capture_start,
    input  logic                                        i_dut_capture_abort,
    input  logic                                        i_dut_capture_system_rdy,
    input  logic [BRAM_ADDR_WIDTH-1:0]                  i_dut_capture_depth,
    input  logic                                        i_dut_capture_trig_en,
    input  logic                                        i_dut_capture_trigger,
    input  logic                                        i_dut_capture_data_en,
    input  logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0]  i_dut_capture_data,
    output logic                                        o_dut_capture_bram_we,
    output logic [BRAM_ADDR_WIDTH-1:0]                  o_dut_capture_bram_addr,
    output logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0]  o_dut_capture_bram_wdata,
    output logic                                        o_dut_capture_busy,
    output logic                                        o_dut_capture_done,
    output logic                                        o_dut_capture_error,
    output logic [BRAM_ADDR_WIDTH:0]                    o_dut_capture_lines
);

    localparam int unsigned DW = ADC_MAX_DATA_SIZE * BRAM_WORD_NUM;
    localparam int unsigned AW = BRAM_ADDR_WIDTH;
    localparam int unsigned LW = BRAM_ADDR_WIDTH + 1;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_FLUSH,
        S_WAIT_TRIG,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t          state_q, state_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic [AW-1:0]   depth_q, depth_n;
    logic            trig_en_q, trig_en_n;
    logic            trig_prev_q;
    logic            we_q, we_n;
    logic [AW-1:0]   addr_q, addr_n;
    logic [DW-1:0]   wdata_q, wdata_n;
    logic            busy_q, busy_n;
    logic            done_q, done_n;
    logic            error_q, error_n;
    logic [LW-1:0]   lines_q, lines_n;
    logic [LW-1:0]   depth_full;
    logic [LW-1:0]   lines_inc;
    logic            trig_edge;

    // Depth 0 encodes a full memory; trigger edge uses the always-registered previous value
    assign depth_full = (depth_q == '0) ? (LW'(1) << AW) : LW'(depth_q);
    assign lines_inc  = lines_q + LW'(1);
    assign trig_edge  = i_dut_capture_trigger && !trig_prev_q;

    // State and output registers
    always_ff @(posedge i_dut_capture_clk or negedge i_dut_capture_reset_n) begin
        if (!i_dut_capture_reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            depth_q     <= '0;
            trig_en_q   <= 1'b0;
            trig_prev_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            lines_q     <= '0;
        end else begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            depth_q     <= depth_n;
            trig_en_q   <= trig_en_n;
            trig_prev_q <= i_dut_capture_trigger;
            we_q        <= we_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            error_q     <= error_n;
            lines_q     <= lines_n;
        end
    end

    // Next-state and next-output logic; abort wins, then ready loss, then data beats
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        depth_n   = depth_q;
        trig_en_n = trig_en_q;
        we_n      = 1'b0;
        addr_n    = addr_q;
        wdata_n   = wdata_q;
        done_n    = done_q;
        error_n   = error_q;
        lines_n   = lines_q;
        busy_n    = (state_q == S_ARM) || (state_q == S_FLUSH) ||
                    (state_q == S_WAIT_TRIG) || (state_q == S_CAPTURE);

        if (i_dut_capture_abort) begin
            state_n = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_dut_capture_start) begin
                        depth_n   = i_dut_capture_depth;
                        trig_en_n = i_dut_capture_trig_en;
                        done_n    = 1'b0;
                        error_n   = 1'b0;
                        lines_n   = '0;
                        addr_n    = '0;
                        state_n   = S_ARM;
                    end
                end
                S_ARM: begin
                    if (i_dut_capture_system_rdy) begin
                        cnt_n   = CW'(FLUSH_BEATS);
                        state_n = S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (!i_dut_capture_system_rdy) begin
                        error_n = 1'b1;
                        state_n = S_IDLE;
                    end else if (i_dut_capture_data_en) begin
                        cnt_n = cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_n = trig_en_q ? S_WAIT_TRIG : S_CAPTURE;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    if (!i_dut_capture_system_rdy) begin
                        error_n = 1'b1;
                        state_n = S_IDLE;
                    end else if (trig_edge) begin
                        state_n = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (!i_dut_capture_system_rdy) begin
                        error_n = 1'b1;
                        state_n = S_IDLE;
                    end else if (i_dut_capture_data_en) begin
                        we_n    = 1'b1;
                        addr_n  = lines_q[AW-1:0];
                        wdata_n = i_dut_capture_data;
                        lines_n = lines_inc;
                        if (lines_inc == depth_full) begin
                            done_n  = 1'b1;
                            state_n = S_DONE;
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign o_dut_capture_bram_we    = we_q;
    assign o_dut_capture_bram_addr  = addr_q;
    assign o_dut_capture_bram_wdata = wdata_q;
    assign o_dut_capture_busy       = busy_q;
    assign o_dut_capture_done       = done_q;
    assign o_dut_capture_error      = error_q;
    assign o_dut_capture_lines      = lines_q;

endmodule

// File: tb/tb_dut_capture_ctrl.sv
// Directed bench for dut_capture_ctrl: default instance plus a 3-bit-address instance.
module tb_dut_capture_ctrl;

    localparam int unsigned DW = 256;
    localparam int unsigned AW = 10;
    localparam int unsigned SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, start_s, abort, rdy, trig_en, trigger, data_en;
    logic [AW-1:0] depth;
    logic [SW-1:0] depth_s;
    logic [DW-1:0] data;

    logic          we, busy, done, error;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW:0]   lines;

    logic          we_s, busy_s, done_s, error_s;
    logic [SW-1:0] addr_s;
    logic [DW-1:0] wdata_s;
    logic [SW:0]   lines_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dut_capture_ctrl u_dut (
        .i_dut_capture_clk        (clk),
        .i_dut_capture_reset_n    (rst_n),
        .i_dut_capture_start      (start),
        .i_dut_capture_abort      (abort),
        .i_dut_capture_system_rdy (rdy),
        .i_dut_capture_depth      (depth),
        .i_dut_capture_trig_en    (trig_en),
        .i_dut_capture_trigger    (trigger),
        .i_dut_capture_data_en    (data_en),
        .i_dut_capture_data       (data),
        .o_dut_capture_bram_we    (we),
        .o_dut_capture_bram_addr  (addr),
        .o_dut_capture_bram_wdata (wdata),
        .o_dut_capture_busy       (busy),
        .o_dut_capture_done       (done),
        .o_dut_capture_error      (error),
        .o_dut_capture_lines      (lines)
    );

    dut_capture_ctrl #(.BRAM_ADDR_WIDTH(SW)) u_small (
        .i_dut_capture_clk        (clk),
        .i_dut_capture_reset_n    (rst_n),
        .i_dut_capture_start      (start_s),
        .i_dut_capture_abort      (abort),
        .i_dut_capture_system_rdy (rdy),
        .i_dut_capture_depth      (depth_s),
        .i_dut_capture_trig_en    (trig_en),
        .i_dut_capture_trigger    (trigger),
        .i_dut_capture_data_en    (data_en),
        .i_dut_capture_data       (data),
        .o_dut_capture_bram_we    (we_s),
        .o_dut_capture_bram_addr  (addr_s),
        .o_dut_capture_bram_wdata (wdata_s),
        .o_dut_capture_busy       (busy_s),
        .o_dut_capture_done       (done_s),
        .o_dut_capture_error      (error_s),
        .o_dut_capture_lines      (lines_s)
    );

    function automatic logic [DW-1:0] mkdata(input int k);
        logic [DW-1:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = 16'(32'hA000 + k);
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    // One data beat on the default instance after `gap` idle cycles, then check its outputs
    task automatic beat(input int gap, input int k, input logic exp_we, input int exp_addr,
                        input logic exp_done, input int exp_lines);
        repeat (gap) cyc();
        data    = mkdata(k);
        data_en = 1'b1;
        cyc();
        data_en = 1'b0;
        total++;
        if (we !== exp_we) begin
            bad++;
            $display("FAIL we beat D%0d: got %b want %b", k, we, exp_we);
        end
        if (exp_we) begin
            total++;
            if (addr !== AW'(exp_addr) || wdata !== mkdata(k)) begin
                bad++;
                $display("FAIL addr/wdata beat D%0d: got addr %0d wdata %h want addr %0d wdata %h",
                         k, addr, wdata[15:0], exp_addr, mkdata(k) & DW'(16'hFFFF));
            end
        end
        total++;
        if (done !== exp_done || lines !== (AW+1)'(exp_lines)) begin
            bad++;
            $display("FAIL done/lines beat D%0d: got done %b lines %0d want done %b lines %0d",
                     k, done, lines, exp_done, exp_lines);
        end
    endtask

    task automatic test_reset();
        total++;
        if (we !== 1'b0 || addr !== '0 || wdata !== '0 || busy !== 1'b0 ||
            done !== 1'b0 || error !== 1'b0 || lines !== '0) begin
            bad++;
            $display("FAIL reset: got we %b addr %0d busy %b done %b error %b lines %0d want all 0",
                     we, addr, busy, done, error, lines);
        end
    endtask

    task automatic test_basic();
        trig_en = 1'b0;
        depth   = AW'(4);
        pulse_start();
        cyc();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic busy: got %b want 1", busy);
        end
        beat(14, 0, 1'b0, 0, 1'b0, 0);
        beat(15, 1, 1'b0, 0, 1'b0, 0);
        beat(15, 2, 1'b1, 0, 1'b0, 1);
        cyc();
        total++;
        if (we !== 1'b0) begin
            bad++;
            $display("FAIL basic we pulse: got %b want 0", we);
        end
        beat(14, 3, 1'b1, 1, 1'b0, 2);
        beat(15, 4, 1'b1, 2, 1'b0, 3);
        beat(15, 5, 1'b1, 3, 1'b1, 4);
        cyc();
        total++;
        if (busy !== 1'b0 || done !== 1'b1) begin
            bad++;
            $display("FAIL basic busy after done: got busy %b done %b want 0 1", busy, done);
        end
        beat(14, 6, 1'b0, 0, 1'b1, 4);
        beat(15, 7, 1'b0, 0, 1'b1, 4);
    endtask

    task automatic test_trigger();
        trig_en = 1'b1;
        depth   = AW'(2);
        pulse_start();
        beat(3, 0, 1'b0, 0, 1'b0, 0);
        beat(3, 1, 1'b0, 0, 1'b0, 0);
        beat(3, 2, 1'b0, 0, 1'b0, 0);
        beat(3, 3, 1'b0, 0, 1'b0, 0);
        beat(3, 4, 1'b0, 0, 1'b0, 0);
        cyc();
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        beat(2, 5, 1'b1, 0, 1'b0, 1);
        beat(3, 6, 1'b1, 1, 1'b1, 2);
        trig_en = 1'b0;
    endtask

    task automatic test_full_depth();
        int writes = 0;
        int first_bad = -1;
        depth_s = '0;
        start_s = 1'b1;
        cyc();
        start_s = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            data    = mkdata(k);
            data_en = 1'b1;
            cyc();
            data_en = 1'b0;
            if (we_s) begin
                if (k < 2 || k > 9 || addr_s !== SW'(k - 2) || wdata_s !== mkdata(k))
                    if (first_bad < 0) first_bad = k;
                writes++;
            end else if (k >= 2 && k <= 9) begin
                if (first_bad < 0) first_bad = k;
            end
        end
        total++;
        if (writes != 8 || first_bad >= 0) begin
            bad++;
            $display("FAIL full depth writes: got %0d writes first bad beat %0d want 8 writes none bad",
                     writes, first_bad);
        end
        total++;
        if (lines_s !== 4'd8 || done_s !== 1'b1) begin
            bad++;
            $display("FAIL full depth end: got lines %0d done %b want 8 1", lines_s, done_s);
        end
    endtask

    task automatic test_rdy_loss();
        depth = AW'(8);
        pulse_start();
        beat(3, 0, 1'b0, 0, 1'b0, 0);
        beat(3, 1, 1'b0, 0, 1'b0, 0);
        beat(3, 2, 1'b1, 0, 1'b0, 1);
        beat(3, 3, 1'b1, 1, 1'b0, 2);
        beat(3, 4, 1'b1, 2, 1'b0, 3);
        rdy     = 1'b0;
        data    = mkdata(5);
        data_en = 1'b1;
        cyc();
        data_en = 1'b0;
        rdy     = 1'b1;
        total++;
        if (we !== 1'b0 || error !== 1'b1 || done !== 1'b0 || lines !== 11'd3) begin
            bad++;
            $display("FAIL rdy loss: got we %b error %b done %b lines %0d want 0 1 0 3",
                     we, error, done, lines);
        end
        beat(3, 6, 1'b0, 0, 1'b0, 3);
        pulse_start();
        total++;
        if (error !== 1'b0 || lines !== '0) begin
            bad++;
            $display("FAIL restart after error: got error %b lines %0d want 0 0", error, lines);
        end
    endtask

    task automatic test_abort();
        beat(3, 0, 1'b0, 0, 1'b0, 0);
        beat(3, 1, 1'b0, 0, 1'b0, 0);
        for (int k = 2; k < 7; k++) beat(3, k, 1'b1, k - 2, 1'b0, k - 1);
        cyc();
        abort   = 1'b1;
        start   = 1'b1;
        data    = mkdata(7);
        data_en = 1'b1;
        cyc();
        abort   = 1'b0;
        start   = 1'b0;
        data_en = 1'b0;
        total++;
        if (we !== 1'b0 || lines !== 11'd5) begin
            bad++;
            $display("FAIL abort cycle: got we %b lines %0d want 0 5", we, lines);
        end
        cyc();
        total++;
        if (busy !== 1'b0 || lines !== 11'd5 || done !== 1'b0 || error !== 1'b0) begin
            bad++;
            $display("FAIL after abort: got busy %b lines %0d done %b error %b want 0 5 0 0",
                     busy, lines, done, error);
        end
    endtask

    task automatic test_back_to_back();
        depth = AW'(4);
        pulse_start();
        beat(3, 0, 1'b0, 0, 1'b0, 0);
        beat(3, 1, 1'b0, 0, 1'b0, 0);
        beat(3, 2, 1'b1, 0, 1'b0, 1);
        depth = AW'(1);
        pulse_start();
        beat(2, 3, 1'b1, 1, 1'b0, 2);
        pulse_start();
        beat(0, 4, 1'b1, 2, 1'b0, 3);
        beat(3, 5, 1'b1, 3, 1'b1, 4);
        depth = AW'(4);
        pulse_start();
        total++;
        if (lines !== '0 || done !== 1'b0) begin
            bad++;
            $display("FAIL restart from done: got lines %0d done %b want 0 0", lines, done);
        end
    endtask

    task automatic test_mid_reset();
        beat(3, 0, 1'b0, 0, 1'b0, 0);
        beat(3, 1, 1'b0, 0, 1'b0, 0);
        beat(3, 2, 1'b1, 0, 1'b0, 1);
        rst_n = 1'b0;
        #1;
        total++;
        if (we !== 1'b0 || addr !== '0 || wdata !== '0 || busy !== 1'b0 || lines !== '0) begin
            bad++;
            $display("FAIL async reset: got we %b addr %0d busy %b lines %0d want all 0",
                     we, addr, busy, lines);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        abort   = 1'b0;
        rdy     = 1'b1;
        trig_en = 1'b0;
        trigger = 1'b0;
        data_en = 1'b0;
        depth   = '0;
        depth_s = '0;
        data    = '0;
        cyc();
        cyc();
        test_reset();
        rst_n = 1'b1;
        cyc();
        test_basic();
        test_trigger();
        test_full_depth();
        test_rdy_loss();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
